// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the unified-memory arbiter.
//   arb_state_t : arbiter FSM states
//   owner_t     : which requester owns the access in flight
//   pick_owner  : priority pick between the fetch and data ports
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_D  = 1'b1
  } owner_t;

  // With rr_en=0 the data port always wins a tie; with rr_en=1 the port
  // that did not own the previous grant wins. A lone requester always wins.
  function automatic owner_t pick_owner(input logic   if_req,
                                        input logic   d_req,
                                        input owner_t last_owner,
                                        input logic   rr_en);
    owner_t win;
    if (if_req && d_req) begin
      if (rr_en && (last_owner == OWNER_D)) win = OWNER_IF;
      else                                  win = OWNER_D;
    end else if (d_req) begin
      win = OWNER_D;
    end else begin
      win = OWNER_IF;
    end
    return win;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the instruction-fetch
// port (IF) and the load/store port (D). One access at a time; the winning
// request's address, write data, write enable and owner are registered on
// grant and held until the memory reports ready.
//
// Ports:
//   clk, arstn                      clock, async active-low reset
//   i_if_req/i_if_addr              fetch request
//   o_if_gnt/o_if_rvalid/o_if_rdata fetch grant and response
//   i_d_req/i_d_we/i_d_addr/i_d_wdata data request
//   o_d_gnt/o_d_rvalid/o_d_rdata    data grant and response (rdata 0 on writes)
//   o_mem_req/o_mem_we/o_mem_addr/o_mem_wdata  memory command (registered)
//   i_mem_ready/i_mem_rdata         memory completion and read data
//
// Build option: define MEM_ARB_RR_EN for round-robin tie-breaking
// (last_owner register); otherwise D has fixed priority over IF.
//
// state  | meaning
// IDLE   | waiting for a request; only state in which a grant can occur
// ACCESS | memory command driven from registers until i_mem_ready
// RESP   | one-cycle rvalid pulse to the owner
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_W_DEF,
  parameter int unsigned DATA_WIDTH = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  i_if_req,
  input  logic [ADDR_WIDTH-1:0] i_if_addr,
  output logic                  o_if_gnt,
  output logic                  o_if_rvalid,
  output logic [DATA_WIDTH-1:0] o_if_rdata,
  input  logic                  i_d_req,
  input  logic                  i_d_we,
  input  logic [ADDR_WIDTH-1:0] i_d_addr,
  input  logic [DATA_WIDTH-1:0] i_d_wdata,
  output logic                  o_d_gnt,
  output logic                  o_d_rvalid,
  output logic [DATA_WIDTH-1:0] o_d_rdata,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic                  i_mem_ready,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  arb_state_t            state_q, state_d;
  owner_t                owner_q, owner_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  owner_t pick;
  logic   grant;

  assign grant = (state_q == IDLE) && (i_if_req || i_d_req);

`ifdef MEM_ARB_RR_EN
  owner_t last_owner_q, last_owner_d;

  assign pick = pick_owner(i_if_req, i_d_req, last_owner_q, 1'b1);

  always_comb begin
    last_owner_d = last_owner_q;
    if (grant) last_owner_d = pick;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) last_owner_q <= OWNER_IF;
    else        last_owner_q <= last_owner_d;
  end
`else
  assign pick = pick_owner(i_if_req, i_d_req, OWNER_IF, 1'b0);
`endif

  assign o_if_gnt = grant && (pick == OWNER_IF);
  assign o_d_gnt  = grant && (pick == OWNER_D);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = ACCESS;
          owner_d = pick;
          if (pick == OWNER_D) begin
            we_d    = i_d_we;
            addr_d  = i_d_addr;
            wdata_d = i_d_wdata;
          end else begin
            // fetches are always reads
            we_d    = 1'b0;
            addr_d  = i_if_addr;
            wdata_d = '0;
          end
        end
      end
      ACCESS: begin
        if (i_mem_ready) begin
          state_d = RESP;
          rdata_d = we_q ? '0 : i_mem_rdata;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= IDLE;
      owner_q <= OWNER_IF;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign o_mem_req   = (state_q == ACCESS);
  // write enable only asserted while the command is live
  assign o_mem_we    = o_mem_req && we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;

  assign o_if_rvalid = (state_q == RESP) && (owner_q == OWNER_IF);
  assign o_d_rvalid  = (state_q == RESP) && (owner_q == OWNER_D);
  assign o_if_rdata  = rdata_q;
  assign o_d_rdata   = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic        i_if_req = 1'b0;
  logic [31:0] i_if_addr = '0;
  logic        o_if_gnt, o_if_rvalid;
  logic [31:0] o_if_rdata;
  logic        i_d_req = 1'b0, i_d_we = 1'b0;
  logic [31:0] i_d_addr = '0, i_d_wdata = '0;
  logic        o_d_gnt, o_d_rvalid;
  logic [31:0] o_d_rdata;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic        i_mem_ready = 1'b0;
  logic [31:0] i_mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .arstn(arstn),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr),
    .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
    .o_d_gnt(o_d_gnt), .o_d_rvalid(o_d_rvalid), .o_d_rdata(o_d_rdata),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        ready;
    logic [31:0] mrdata;
    logic [3:0]  e_flags;  // {if_gnt, d_gnt, mem_req, mem_we}
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [1:0]  e_rv;     // {if_rvalid, d_rvalid}
    logic [1:0]  push;     // {push, owner_is_d}
    logic [31:0] push_data;
  } vec_t;

  typedef struct {
    logic        is_d;
    logic [31:0] data;
  } resp_t;

  vec_t  tbl[$];
  resp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t v(input logic ir, input logic [31:0] ia,
                             input logic dr, input logic dw,
                             input logic [31:0] da, input logic [31:0] dwd,
                             input logic rdy, input logic [31:0] mrd,
                             input logic [3:0] ef, input logic [31:0] ea,
                             input logic [31:0] ewd, input logic [1:0] erv,
                             input logic [1:0] ps, input logic [31:0] pd);
    vec_t t;
    t.if_req = ir; t.if_addr = ia; t.d_req = dr; t.d_we = dw;
    t.d_addr = da; t.d_wdata = dwd; t.ready = rdy; t.mrdata = mrd;
    t.e_flags = ef; t.e_addr = ea; t.e_wdata = ewd; t.e_rv = erv;
    t.push = ps; t.push_data = pd;
    return t;
  endfunction

  task automatic push_exp(input logic is_d, input logic [31:0] data);
    resp_t r;
    r.is_d = is_d;
    r.data = data;
    sb.push_back(r);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Response scoreboard: every rvalid must match the oldest expected response.
  always @(negedge clk) begin
    resp_t r;
    if (o_if_rvalid || o_d_rvalid) begin
      chk("rvalid_onehot", {31'b0, o_if_rvalid & o_d_rvalid}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid actual if=%0b d=%0b required none", o_if_rvalid, o_d_rvalid);
      end else begin
        r = sb.pop_front();
        chk("resp_owner_d", {31'b0, o_d_rvalid}, {31'b0, r.is_d});
        chk("resp_rdata", r.is_d ? o_d_rdata : o_if_rdata, r.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_if_gnt"},     {31'b0, o_if_gnt}, 0);
    chk({tag, "_d_gnt"},      {31'b0, o_d_gnt}, 0);
    chk({tag, "_mem_req"},    {31'b0, o_mem_req}, 0);
    chk({tag, "_mem_we"},     {31'b0, o_mem_we}, 0);
    chk({tag, "_mem_addr"},   o_mem_addr, 0);
    chk({tag, "_mem_wdata"},  o_mem_wdata, 0);
    chk({tag, "_if_rvalid"},  {31'b0, o_if_rvalid}, 0);
    chk({tag, "_d_rvalid"},   {31'b0, o_d_rvalid}, 0);
    chk({tag, "_if_rdata"},   o_if_rdata, 0);
    chk({tag, "_d_rdata"},    o_d_rdata, 0);
  endtask

  initial begin
    // D write, three wait cycles, ready on 4th ACCESS cycle (read data must be dropped)
    tbl.push_back(v(0,0, 1,1,32'h100,32'hDEADBEEF, 0,0, 4'b0100, 0,0, 2'b00, 2'b00,0));
    tbl.push_back(v(0,0, 0,0,0,0, 0,0, 4'b0011, 32'h100,32'hDEADBEEF, 2'b00, 2'b00,0));
    tbl.push_back(v(0,0, 0,0,0,0, 0,0, 4'b0011, 32'h100,32'hDEADBEEF, 2'b00, 2'b00,0));
    tbl.push_back(v(0,0, 0,0,0,0, 0,0, 4'b0011, 32'h100,32'hDEADBEEF, 2'b00, 2'b00,0));
    tbl.push_back(v(0,0, 0,0,0,0, 1,32'h12345678, 4'b0011, 32'h100,32'hDEADBEEF, 2'b00, 2'b11,0));
    tbl.push_back(v(0,0, 0,0,0,0, 1,32'h55, 4'b0000, 0,0, 2'b01, 2'b00,0));
    // IF read, ready in first ACCESS cycle
    tbl.push_back(v(1,32'h10, 0,0,0,0, 0,0, 4'b1000, 0,0, 2'b00, 2'b00,0));
    tbl.push_back(v(0,0, 0,0,0,0, 1,32'h00500093, 4'b0010, 32'h10,0, 2'b00, 2'b10,32'h00500093));
    tbl.push_back(v(0,0, 0,0,0,0, 0,0, 4'b0000, 0,0, 2'b10, 2'b00,0));
    // ready while IDLE is ignored
    tbl.push_back(v(0,0, 0,0,0,0, 1,32'hFFFFFFFF, 4'b0000, 0,0, 2'b00, 2'b00,0));
    tbl.push_back(v(0,0, 0,0,0,0, 0,0, 4'b0000, 0,0, 2'b00, 2'b00,0));
    // simultaneous requests, round 1: D wins in both builds (last grant was IF)
    tbl.push_back(v(1,32'h20, 1,0,32'h200,0, 0,0, 4'b0100, 0,0, 2'b00, 2'b00,0));
    tbl.push_back(v(1,32'h20, 0,0,0,0, 1,32'hAAAA5555, 4'b0010, 32'h200,0, 2'b00, 2'b11,32'hAAAA5555));
    tbl.push_back(v(1,32'h20, 0,0,0,0, 0,0, 4'b0000, 0,0, 2'b01, 2'b00,0));
`ifdef MEM_ARB_RR_EN
    // round 2: IF wins, D keeps requesting
    tbl.push_back(v(1,32'h20, 1,0,32'h204,0, 0,0, 4'b1000, 0,0, 2'b00, 2'b00,0));
    tbl.push_back(v(0,0, 1,0,32'h204,0, 1,32'h0BADF00D, 4'b0010, 32'h20,0, 2'b00, 2'b10,32'h0BADF00D));
    tbl.push_back(v(0,0, 1,0,32'h204,0, 0,0, 4'b0000, 0,0, 2'b10, 2'b00,0));
`else
    // round 2: D wins again, IF keeps requesting
    tbl.push_back(v(1,32'h20, 1,0,32'h204,0, 0,0, 4'b0100, 0,0, 2'b00, 2'b00,0));
    tbl.push_back(v(1,32'h20, 0,0,0,0, 1,32'h0BADF00D, 4'b0010, 32'h204,0, 2'b00, 2'b11,32'h0BADF00D));
    tbl.push_back(v(1,32'h20, 0,0,0,0, 0,0, 4'b0000, 0,0, 2'b01, 2'b00,0));
`endif
    // loser drops its request before being granted
    tbl.push_back(v(0,0, 0,0,0,0, 0,0, 4'b0000, 0,0, 2'b00, 2'b00,0));

    #3;
    chk_all_zero("reset");
    #9 arstn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      cyc();
      i_if_req = tbl[i].if_req;   i_if_addr = tbl[i].if_addr;
      i_d_req = tbl[i].d_req;     i_d_we = tbl[i].d_we;
      i_d_addr = tbl[i].d_addr;   i_d_wdata = tbl[i].d_wdata;
      i_mem_ready = tbl[i].ready; i_mem_rdata = tbl[i].mrdata;
      if (tbl[i].push[1]) push_exp(tbl[i].push[0], tbl[i].push_data);
      @(negedge clk);
      chk($sformatf("r%0d_if_gnt", i),    {31'b0, o_if_gnt},    {31'b0, tbl[i].e_flags[3]});
      chk($sformatf("r%0d_d_gnt", i),     {31'b0, o_d_gnt},     {31'b0, tbl[i].e_flags[2]});
      chk($sformatf("r%0d_mem_req", i),   {31'b0, o_mem_req},   {31'b0, tbl[i].e_flags[1]});
      chk($sformatf("r%0d_mem_we", i),    {31'b0, o_mem_we},    {31'b0, tbl[i].e_flags[0]});
      chk($sformatf("r%0d_if_rvalid", i), {31'b0, o_if_rvalid}, {31'b0, tbl[i].e_rv[1]});
      chk($sformatf("r%0d_d_rvalid", i),  {31'b0, o_d_rvalid},  {31'b0, tbl[i].e_rv[0]});
      if (tbl[i].e_flags[1])
        chk($sformatf("r%0d_mem_addr", i), o_mem_addr, tbl[i].e_addr);
      if (tbl[i].e_flags[1] && tbl[i].e_flags[0])
        chk($sformatf("r%0d_mem_wdata", i), o_mem_wdata, tbl[i].e_wdata);
    end

    // IF request raised while a D read waits in ACCESS
    cyc();
    i_d_req = 1; i_d_we = 0; i_d_addr = 32'h300;
    @(negedge clk);
    chk("hold_d_gnt", {31'b0, o_d_gnt}, 1);
    cyc();
    i_d_req = 0; i_d_addr = 32'h3FC; i_if_req = 1; i_if_addr = 32'h40;
    @(negedge clk);
    chk("hold_if_gnt_acc0", {31'b0, o_if_gnt}, 0);
    chk("hold_addr_acc0", o_mem_addr, 32'h300);
    for (int k = 1; k < 3; k++) begin
      cyc();
      @(negedge clk);
      chk($sformatf("hold_if_gnt_acc%0d", k), {31'b0, o_if_gnt}, 0);
      chk($sformatf("hold_addr_acc%0d", k), o_mem_addr, 32'h300);
    end
    cyc();
    i_mem_ready = 1; i_mem_rdata = 32'hCAFE0001;
    push_exp(1'b1, 32'hCAFE0001);
    @(negedge clk);
    chk("hold_if_gnt_ready", {31'b0, o_if_gnt}, 0);
    cyc();
    i_mem_ready = 0;
    @(negedge clk);
    chk("hold_if_gnt_resp", {31'b0, o_if_gnt}, 0);
    cyc();
    @(negedge clk);
    chk("hold_if_gnt_idle", {31'b0, o_if_gnt}, 1);
    cyc();
    i_if_req = 0; i_mem_ready = 1; i_mem_rdata = 32'h11112222;
    push_exp(1'b0, 32'h11112222);
    @(negedge clk);
    chk("hold_if_mem_addr", o_mem_addr, 32'h40);
    chk("hold_if_mem_req", {31'b0, o_mem_req}, 1);
    cyc();
    i_mem_ready = 0;
    @(negedge clk);

    // reset during ACCESS abandons the access
    cyc();
    i_d_req = 1; i_d_we = 1; i_d_addr = 32'h500; i_d_wdata = 32'h77;
    @(negedge clk);
    chk("rst_d_gnt", {31'b0, o_d_gnt}, 1);
    cyc();
    i_d_req = 0;
    @(negedge clk);
    chk("rst_pre_mem_req", {31'b0, o_mem_req}, 1);
    chk("rst_pre_mem_we", {31'b0, o_mem_we}, 1);
    #2 arstn = 1'b0;
    i_mem_ready = 1; i_mem_rdata = 32'h99999999;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    #2 arstn = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc();
      @(negedge clk);
      chk($sformatf("postrst_mem_req%0d", k), {31'b0, o_mem_req}, 0);
      chk($sformatf("postrst_rvalid%0d", k), {30'b0, o_if_rvalid, o_d_rvalid}, 0);
    end
    cyc();
    i_mem_ready = 0; i_if_req = 1; i_if_addr = 32'h60;
    @(negedge clk);
    chk("postrst_if_gnt", {31'b0, o_if_gnt}, 1);
    cyc();
    i_if_req = 0; i_mem_ready = 1; i_mem_rdata = 32'h0000600D;
    push_exp(1'b0, 32'h0000600D);
    @(negedge clk);
    chk("postrst_mem_addr", o_mem_addr, 32'h60);
    cyc();
    i_mem_ready = 0;
    @(negedge clk);
    cyc();
    @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
